// File: rtl/n8_responder_if.sv
// Host-side signal bundle for the N8 controller responder: button inputs, the
// host reader's latch/pulse strobes, and the serial data and status returned to it.
interface n8_responder_if;
  logic [7:0]  buttons;
  logic        latch_in;
  logic        pulse_in;
  logic        data_out;
  logic        active;
  logic        frame_done;
  logic [15:0] frames;

  modport master (
    output buttons, latch_in, pulse_in,
    input  data_out, active, frame_done, frames
  );

  modport slave (
    input  buttons, latch_in, pulse_in,
    output data_out, active, frame_done, frames
  );
endinterface

// File: rtl/n8_responder.sv
// N8-style controller responder: it latches eight buttons on a host latch and
// shifts them out active-low, one bit per host pulse, with a stall timeout.
module n8_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset_n,
  n8_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] latch_sync, pulse_sync;
  logic                   latch_dly, pulse_dly;
  logic                   latch_lvl, latch_rise, pulse_rise;

  state_t      state, state_n;
  logic [7:0]  shreg, shreg_n;
  logic [3:0]  count, count_n, count_inc;
  logic [TW-1:0] timeout, timeout_n;
  logic [15:0] frames_q, frames_n;
  logic        data_q, data_n;
  logic        active_q, active_n;
  logic        done_q, done_n;

  // The strobes come from another clock domain; the delayed copy of the last
  // stage provides the single-cycle rising-edge detect.
  // NOTE: sequential state uses <= so every flop samples the pre-edge values;
  // blocking assignments here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      latch_dly  <= 1'b0;
      pulse_dly  <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], bus.latch_in};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], bus.pulse_in};
      latch_dly  <= latch_sync[SYNC_STAGES-1];
      pulse_dly  <= pulse_sync[SYNC_STAGES-1];
    end
  end

  assign latch_lvl  = latch_sync[SYNC_STAGES-1];
  assign latch_rise = latch_lvl & ~latch_dly;
  assign pulse_rise = pulse_sync[SYNC_STAGES-1] & ~pulse_dly;

  // NOTE: the shift register is reset along with the control state so an
  // aborted frame can never leak stale button bits into the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      count    <= '0;
      timeout  <= '0;
      frames_q <= '0;
      data_q   <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      count    <= count_n;
      timeout  <= timeout_n;
      frames_q <= frames_n;
      data_q   <= data_n;
      active_q <= active_n;
      done_q   <= done_n;
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the case
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    count_n   = count;
    timeout_n = timeout;
    frames_n  = frames_q;
    data_n    = data_q;
    done_n    = 1'b0;
    count_inc = count + 4'd1;

    if (latch_rise) begin
      // A fresh latch always restarts the frame, whatever else happens.
      state_n   = LOAD;
      shreg_n   = bus.buttons;
      count_n   = '0;
      timeout_n = '0;
      data_n    = ~bus.buttons[0];
    end else begin
      unique case (state)
        IDLE: data_n = 1'b1;

        LOAD: begin
          shreg_n   = bus.buttons;
          count_n   = '0;
          timeout_n = '0;
          data_n    = ~bus.buttons[0];
          if (!latch_lvl) state_n = SHIFT;
        end

        SHIFT: begin
          if (pulse_rise && !latch_lvl) begin
            shreg_n   = {1'b0, shreg[7:1]};
            count_n   = count_inc;
            timeout_n = '0;
            data_n    = (count_inc < 4'd8) ? ~shreg[1] : 1'b1;
            if (count_inc == 4'd8) begin
              state_n  = DONE;
              done_n   = 1'b1;
              frames_n = frames_q + 16'd1;
            end
          end else if (timeout == TO_LAST) begin
            state_n   = IDLE;
            timeout_n = '0;
            data_n    = 1'b1;
          end else begin
            timeout_n = timeout + TW'(1);
          end
        end

        DONE: data_n = 1'b1;

        default: begin
          state_n = IDLE;
          data_n  = 1'b1;
        end
      endcase
    end

    active_n = (state_n == LOAD) || (state_n == SHIFT);
  end

  assign bus.data_out   = data_q;
  assign bus.active     = active_q;
  assign bus.frame_done = done_q;
  assign bus.frames     = frames_q;

endmodule

// File: tb/tb_n8_responder.sv
// Directed bench for n8_responder: expected serial bits are queued when a pulse
// is driven and compared when the synchronized result appears on data_out.
module tb_n8_responder;
  localparam int SYNC = 2;
  localparam int TO   = 2000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  n8_responder_if bus ();

  n8_responder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int   total = 0;
  int   passed = 0;
  int   fd_count = 0;
  int   pulse_n = 0;
  logic [7:0] latched;
  logic prev_exp;
  logic exp_q[$];

  always @(posedge clk) if (bus.frame_done === 1'b1) fd_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Latch held 600 clocks; buttons switch from b to b2 while in LOAD.
  task automatic do_latch(input logic [7:0] b, input logic [7:0] b2);
    logic e;
    bus.buttons  = b;
    pulse_n      = 0;
    bus.latch_in = 1'b1;
    tick(3);
    e = ~b[0];
    check("load_data", e, bus.data_out) ;
    check("load_active", bus.active, 1);
    bus.buttons = b2;
    latched     = b2;
    tick(1);
    e = ~b2[0];
    check("load_follow", bus.data_out, e);
    prev_exp = e;
    tick(596);
    bus.latch_in = 1'b0;
    tick(300);
  endtask

  // One pulse: 300 clk high, 300 clk low; result must land exactly on edge 3.
  task automatic send_pulse(input string tag);
    logic e;
    pulse_n++;
    e = (pulse_n < 8) ? ~latched[pulse_n] : 1'b1;
    exp_q.push_back(e);
    bus.pulse_in = 1'b1;
    tick(2);
    check({tag, "_early"}, bus.data_out, prev_exp);
    tick(1);
    check(tag, bus.data_out, exp_q.pop_front());
    prev_exp = e;
    tick(297);
    bus.pulse_in = 1'b0;
    tick(300);
  endtask

  initial begin
    bus.buttons  = 8'h00;
    bus.latch_in = 1'b0;
    bus.pulse_in = 1'b0;
    #35;
    check("rst_data", bus.data_out, 1);
    check("rst_active", bus.active, 0);
    check("rst_done", bus.frame_done, 0);
    check("rst_frames", bus.frames, 0);
    reset_n = 1'b1;
    tick(2);

    // Full frame, 0000_0101: buttons change in LOAD is followed, in SHIFT ignored
    do_latch(8'h00, 8'h05);
    send_pulse("full_p1");
    bus.buttons = 8'hFA;
    for (int i = 2; i <= 8; i++) send_pulse($sformatf("full_p%0d", i));
    check("full_fd", fd_count, 1);
    check("full_frames", bus.frames, 1);
    check("full_done_low", bus.frame_done, 0);
    check("full_active", bus.active, 0);

    // Extra pulses beyond the eighth are ignored
    do_latch(8'h3C, 8'h3C);
    for (int i = 1; i <= 8; i++) send_pulse($sformatf("xtra_p%0d", i));
    check("xtra_fd8", fd_count, 2);
    send_pulse("xtra_p9");
    send_pulse("xtra_p10");
    check("xtra_fd10", fd_count, 2);
    check("xtra_frames", bus.frames, 2);

    // Re-latch after 4 pulses restarts the frame with all buttons pressed
    do_latch(8'h05, 8'h05);
    for (int i = 1; i <= 4; i++) send_pulse($sformatf("rl_a%0d", i));
    do_latch(8'hFF, 8'hFF);
    for (int i = 1; i <= 7; i++) send_pulse($sformatf("rl_b%0d", i));
    check("rl_fd7", fd_count, 2);
    send_pulse("rl_b8");
    check("rl_fd", fd_count, 3);
    check("rl_frames", bus.frames, 3);

    // Timeout: 3 pulses then silence; IDLE exactly TO clocks after the last edge
    do_latch(8'h81, 8'h81);
    for (int i = 1; i <= 3; i++) send_pulse($sformatf("to_p%0d", i));
    tick(TO - 598);
    check("to_pre_active", bus.active, 1);
    tick(1);
    check("to_active", bus.active, 0);
    check("to_data", bus.data_out, 1);
    check("to_frames", bus.frames, 3);
    check("to_fd", fd_count, 3);

    // Asynchronous reset mid-SHIFT while data_out is low
    do_latch(8'hFF, 8'hFF);
    send_pulse("rs_p1");
    send_pulse("rs_p2");
    #5;
    reset_n = 1'b0;
    #1;
    check("rs_data", bus.data_out, 1);
    check("rs_active", bus.active, 0);
    check("rs_frames", bus.frames, 0);
    check("rs_done", bus.frame_done, 0);
    #3;
    reset_n = 1'b1;
    tick(2);
    for (int i = 1; i <= 3; i++) begin
      bus.pulse_in = 1'b1;
      tick(3);
      check($sformatf("rs_ign_data%0d", i), bus.data_out, 1);
      check($sformatf("rs_ign_act%0d", i), bus.active, 0);
      bus.pulse_in = 1'b0;
      tick(3);
    end
    check("rs_fd", fd_count, 3);
    do_latch(8'h01, 8'h01);
    for (int i = 1; i <= 8; i++) send_pulse($sformatf("post_p%0d", i));
    check("post_frames", bus.frames, 1);
    check("post_fd", fd_count, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/n8_responder.md
N8_RESPONDER -- requirements
Module: n8_responder

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of input synchronizer flops on latch_in and pulse_in (minimum 2).
REQ-002 Parameter: TIMEOUT_CYCLES, default 50000, number of clk cycles without a pulse edge in SHIFT before the frame is abandoned.
REQ-003 Port: clk  input  1  system clock, 50 MHz (CLOCK_50 at top level); all state updates on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: buttons  input  8  button states, 1 = pressed; bit0 A, bit1 B, bit2 select, bit3 start, bit4 up, bit5 down, bit6 left, bit7 right.
REQ-006 Port: latch_in  input  1  controller latch from the host reader; asynchronous to clk.
REQ-007 Port: pulse_in  input  1  controller clock pulse from the host reader; asynchronous to clk.
REQ-008 Port: data_out  output  1  serial button data to the host, active-low (0 = pressed).
REQ-009 Port: active  output  1  high while the state is LOAD or SHIFT.
REQ-010 Port: frame_done  output  1  single-cycle pulse when all 8 bits have been shifted out.
REQ-011 Port: frames  output  16  count of completed frames.

Function
REQ-012 The block SHALL pass latch_in and pulse_in through SYNC_STAGES flops, then through a rising-edge detector (last stage AND NOT delayed copy).
REQ-013 States: IDLE, LOAD, SHIFT, DONE; encoding is free.
REQ-014 A synced latch rising edge in any state SHALL move the block to LOAD. This overrides pulse edges, timeout and DONE in the same cycle.
REQ-015 In LOAD, every cycle: shreg <= buttons, count <= 0, data_out <= ~buttons[0].
REQ-016 LOAD -> SHIFT when synced latch is low.
REQ-017 Pulse edges SHALL be ignored while synced latch is high.
REQ-018 On a synced pulse edge in SHIFT:
- shreg shifts right with 0 fill and count increments;
- data_out <= ~shreg[1] when the new count < 8, else data_out <= 1.
REQ-019 When count reaches 8, the block SHALL go SHIFT -> DONE, assert frame_done for exactly one cycle and increment frames.
REQ-020 frames SHALL wrap from 16'hFFFF to 0.
REQ-021 In DONE and IDLE, data_out SHALL be 1 and pulse edges SHALL be ignored. DONE stays until the next latch edge.
REQ-022 In SHIFT, a timeout counter SHALL clear on each pulse edge and on entry, and increment otherwise.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL go SHIFT -> IDLE with data_out = 1. No frame_done pulse and no frames increment.
REQ-024 Latency: a raw latch_in or pulse_in rising edge SHALL affect data_out/state on the (SYNC_STAGES+1)th rising clk edge after it, i.e. 3 edges at the default.
REQ-025 Button changes during LOAD SHALL be reflected on data_out one clk later. Button changes during SHIFT SHALL NOT affect the frame in progress.
REQ-026 data_out, active and frame_done SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-027 While reset_n = 0, asynchronously and regardless of clk:
- state = IDLE, shreg = 0, count = 0, timeout = 0, all synchronizer and edge flops = 0;
- data_out = 1, active = 0, frame_done = 0, frames = 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no frame_done. After release, the block SHALL wait for a fresh latch edge.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Full frame: buttons = 8'b0000_0101, latch high 600 clk then low, 8 pulses each 300 clk high/300 clk low -> data_out sequence 0,1,0,1,1,1,1,1, then 1; one frame_done pulse; frames = 1.
- Latency: pulse_in raw rise at a known edge -> data_out changes exactly 3 clk edges later.
- Timeout: latch then 3 pulses, then silence -> IDLE after TIMEOUT_CYCLES, data_out = 1, frame_done never asserted, frames unchanged.
- Re-latch mid-SHIFT after 4 pulses with buttons = 8'hFF -> LOAD, data_out = 0, count restarts; the next frame completes normally.
- Extra pulses: 10 pulses after a latch -> frame_done once at pulse 8; pulses 9 and 10 ignored; data_out stays 1.
- Reset: reset_n low mid-SHIFT -> data_out = 1 and active = 0 immediately, without a clk edge; frames = 0; pulses before the next latch are ignored.
